seq_calculator: RTL and testbench

//  Parametrised, clocked four-function unsigned calculator (add/sub/mul/div) with start/done handshake.

---
 rtl/seq_calculator.sv | 142 ++++++++++++++
 tb/tb_seq_calculator.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/seq_calculator.sv
// Four-function unsigned calculator with start/done handshake; mul/div iterate one bit per cycle.
// Define CALC_REM_EN to add the registered remainder output rem.
module seq_calculator #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] result,
`ifdef CALC_REM_EN
  output logic           div_by_zero,
  output logic [W-1:0]   rem
`else
  output logic           div_by_zero
`endif
);

  localparam int CW = $clog2(W + 1);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {IDLE, EXEC, ITER, DONE} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  count;
  logic           accept;
  state_t         launch;

  logic [1:0]     op_r;
  logic [W-1:0]   a_r, b_r;
  logic [2*W-1:0] acc, mcand;
  logic [W-1:0]   mplier;
  logic [W-1:0]   part, quo;

  logic [W:0]     div_trial, div_diff;
  logic           div_ge;

  assign busy   = (state == EXEC) || (state == ITER);
  assign done   = (state == DONE);
  assign accept = start && !busy;

  // Division by zero short-circuits straight to the finalise state.
  assign launch = (op[1] && !(op[0] && (b == '0))) ? ITER : EXEC;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = launch;
      ITER:    if (count == CW'(W - 1)) state_nxt = EXEC;
      EXEC:    state_nxt = DONE;
      DONE:    state_nxt = start ? launch : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    div_trial = {part, quo[W-1]};
    div_diff  = div_trial - {1'b0, b_r};
    div_ge    = (div_trial >= {1'b0, b_r});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        count <= '0;
      else if (state == ITER)
        count <= count + 1'b1;
    end
  end

  // Operand capture and iteration engines; data only, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_r   <= op;
      a_r    <= a;
      b_r    <= b;
      acc    <= '0;
      mcand  <= {{W{1'b0}}, a};
      mplier <= b;
      part   <= '0;
      quo    <= a;
    end else if (state == ITER) begin
      if (op_r == OP_MUL) begin
        if (mplier[0])
          acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end else begin
        part <= div_ge ? div_diff[W-1:0] : div_trial[W-1:0];
        quo  <= {quo[W-2:0], div_ge};
      end
    end
  end

  // Finalise: outputs only move here, on accept (flag clear) or on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result      <= '0;
      div_by_zero <= 1'b0;
`ifdef CALC_REM_EN
      rem         <= '0;
`endif
    end else if (accept) begin
      div_by_zero <= 1'b0;
    end else if (state == EXEC) begin
`ifdef CALC_REM_EN
      rem <= '0;
`endif
      case (op_r)
        OP_ADD: result <= {{W{1'b0}}, a_r} + {{W{1'b0}}, b_r};
        OP_SUB: result <= {{W{1'b0}}, a_r} - {{W{1'b0}}, b_r};
        OP_MUL: result <= acc;
        default: begin
          if (b_r == '0) begin
            result      <= '1;
            div_by_zero <= 1'b1;
`ifdef CALC_REM_EN
            rem         <= a_r;
`endif
          end else begin
            result <= {{W{1'b0}}, quo};
`ifdef CALC_REM_EN
            rem    <= part;
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_calculator.sv
// Scoreboard bench for seq_calculator (W=4): stimulus pushes expectations, monitor checks on done.
module tb_seq_calculator;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [1:0]     op = 2'b00;
  logic [W-1:0]   a = '0, b = '0;
  logic           busy, done, div_by_zero;
  logic [2*W-1:0] result;
  logic [W-1:0]   rem;

  typedef struct {
    logic [2*W-1:0] res;
    logic           dbz;
    logic [W-1:0]   rem;
    int             cyc;
    string          name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;

  seq_calculator #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
`ifdef CALC_REM_EN
    .div_by_zero(div_by_zero), .rem(rem)
`else
    .div_by_zero(div_by_zero)
`endif
  );

`ifndef CALC_REM_EN
  assign rem = '0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(result), 32'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, "_result"}, 32'(result), 32'(e.res));
        chk({e.name, "_dbz"}, 32'(div_by_zero), 32'(e.dbz));
        chk({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
        chk({e.name, "_busy_at_done"}, 32'(busy), 32'h0);
`ifdef CALC_REM_EN
        chk({e.name, "_rem"}, 32'(rem), 32'(e.rem));
`endif
      end
    end
  end

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic issue(input string name, input logic [1:0] o, input logic [W-1:0] xa,
                       input logic [W-1:0] xb, input logic [2*W-1:0] res,
                       input logic dbz, input logic [W-1:0] r, input int lat);
    exp_t e;
    int guard = 0;
    while (busy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (busy) chk({name, "_wait_idle"}, 32'(busy), 32'h0);
    start = 1'b1; op = o; a = xa; b = xb;
    e.res = res; e.dbz = dbz; e.rem = r; e.cyc = cyc + 1 + lat; e.name = name;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk({name, "_busy_after_accept"}, 32'(busy), 32'h1);
    chk({name, "_dbz_cleared"}, 32'(div_by_zero), 32'h0);
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_outstanding", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    #1;
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_result", 32'(result), 32'h0);
    chk("reset_dbz", 32'(div_by_zero), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue("add_15_15", 2'b00, 4'd15, 4'd15, 8'h1E, 1'b0, 4'd0, 1);
    issue("sub_3_5",   2'b01, 4'd3,  4'd5,  8'hFE, 1'b0, 4'd0, 1);
    issue("sub_9_9",   2'b01, 4'd9,  4'd9,  8'h00, 1'b0, 4'd0, 1);
    issue("sub_0_15",  2'b01, 4'd0,  4'd15, 8'hF1, 1'b0, 4'd0, 1);
    issue("add_0_0",   2'b00, 4'd0,  4'd0,  8'h00, 1'b0, 4'd0, 1);
    drain();
    repeat (2) @(negedge clk);

    issue("mul_15_15", 2'b10, 4'd15, 4'd15, 8'hE1, 1'b0, 4'd0, 5);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("mul_busy_hold", 32'(busy), 32'h1);
    end
    issue("mul_0_7",   2'b10, 4'd0,  4'd7,  8'h00, 1'b0, 4'd0, 5);
    issue("mul_15_1",  2'b10, 4'd15, 4'd1,  8'h0F, 1'b0, 4'd0, 5);
    issue("div_13_4",  2'b11, 4'd13, 4'd4,  8'h03, 1'b0, 4'd1, 5);
    issue("div_7_0",   2'b11, 4'd7,  4'd0,  8'hFF, 1'b1, 4'd7, 1);
    issue("div_15_1",  2'b11, 4'd15, 4'd1,  8'h0F, 1'b0, 4'd0, 5);
    issue("div_2_15",  2'b11, 4'd2,  4'd15, 8'h00, 1'b0, 4'd2, 5);
    drain();

    // Start pulsed mid-multiply must be ignored; follow-up issues on the done cycle.
    issue("mul_6_7", 2'b10, 4'd6, 4'd7, 8'h2A, 1'b0, 4'd0, 5);
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 4'd1; b = 4'd1;
    @(negedge clk);
    start = 1'b0;
    issue("add_1_1_b2b", 2'b00, 4'd1, 4'd1, 8'h02, 1'b0, 4'd0, 1);
    drain();

    // Asynchronous reset during a divide discards it.
    issue("div_13_4_rst", 2'b11, 4'd13, 4'd4, 8'h03, 1'b0, 4'd1, 5);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_dbz", 32'(div_by_zero), 32'h0);
`ifdef CALC_REM_EN
    chk("rst_rem", 32'(rem), 32'h0);
`endif
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue("div_9_2_after_rst", 2'b11, 4'd9, 4'd2, 8'h04, 1'b0, 4'd1, 5);
    drain();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
